// File: rtl/apb_uart_rx.sv
// APB-readable UART receiver: 8N1 deserialiser (8E1 when APB_UART_RX_PARITY_EN
// is defined) feeding an 8-bit receive FIFO, with RXDATA/STATUS/LEVEL registers.
module apb_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_LSB_W   = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        uart_rx_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        rx_irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LEVEL  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef APB_UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_e;

    // Receiver state, kept as a named register so checkers can bind to it.
    rx_state_e     state_q;
    rx_state_e     state_d;

    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;

    logic          half_tick;
    logic          bit_tick;
    logic          start_edge;
    logic          shift_en;
    logic          frame_push;
    logic          ferr_set;
`ifdef APB_UART_RX_PARITY_EN
    logic          perr_set;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   level;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          ovr_set;

    logic          ovr_q;
    logic          ferr_q;
    logic          perr_q;

    logic          apb_access;
    logic [1:0]    reg_sel;
    logic          sts_wr;
    logic [31:0]   rdata;

    // ------------------------------------------------------------------
    // Input synchroniser. sync_fill marks when rx_s holds a real line
    // sample rather than its reset value, so reset never fakes an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'd0;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            if (sync_fill != 2'd2) begin
                sync_fill <= sync_fill + 2'd1;
            end
        end
    end

    assign half_tick = (baud_q == HALF_BIT);
    assign bit_tick  = (baud_q == FULL_BIT);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_edge = 1'b0;
        shift_en   = 1'b0;
        frame_push = 1'b0;
        ferr_set   = 1'b0;
`ifdef APB_UART_RX_PARITY_EN
        perr_set   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (armed && !rx_s) begin
                    start_edge = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef APB_UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef APB_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    perr_set = ^{shreg_q, rx_s};
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    frame_push = rx_s;
                    ferr_set   = !rx_s;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge detect is armed only after rx_s has been seen high in IDLE, so a
    // held-low line (break, or a stop-bit error) cannot start a new frame.
    always_ff @(posedge pclk) begin
        if (preset) begin
            armed     <= 1'b0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            if ((state_q != ST_IDLE) || start_edge) begin
                armed <= 1'b0;
            end else if ((sync_fill == 2'd2) && rx_s) begin
                armed <= 1'b1;
            end

            if ((state_q == ST_IDLE) || ((state_q == ST_START) && half_tick) || bit_tick) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + CW'(1);
            end

            if (state_q == ST_START) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end

            if (shift_en) begin
                shreg_q <= {rx_s, shreg_q[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // APB decode. Handshake: no wait states and no pready; every cycle with
    // psel_i & penable_i high is one completed transfer (read or write).
    // ------------------------------------------------------------------
    assign apb_access = psel_i & penable_i;
    assign reg_sel    = paddr_i[ADDR_LSB_W-1 -: 2];
    assign sts_wr     = apb_access & pwrite_i & (reg_sel == REG_STATUS);

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level      = wr_ptr_q - rd_ptr_q;

    assign pop     = apb_access & !pwrite_i & (reg_sel == REG_RXDATA) & !fifo_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = frame_push & (!fifo_full | pop);
    assign ovr_set = frame_push & fifo_full & !pop;

    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem[wr_idx] <= shreg_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as a W1C clear wins.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_set  | (ovr_q  & ~(sts_wr & pwdata_i[2]));
            ferr_q <= ferr_set | (ferr_q & ~(sts_wr & pwdata_i[3]));
        end
    end

`ifdef APB_UART_RX_PARITY_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_set | (perr_q & ~(sts_wr & pwdata_i[4]));
        end
    end
`else
    assign perr_q = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_RXDATA: if (!fifo_empty) rdata = {24'd0, mem[rd_idx]};
            REG_STATUS: rdata = {27'd0, perr_q, ferr_q, ovr_q, fifo_full, fifo_empty};
            REG_LEVEL:  rdata = 32'(level);
            default:    rdata = '0;
        endcase
    end

    assign prdata_o = (psel_i && !pwrite_i) ? rdata : 32'd0;
    assign rx_irq_o = !fifo_empty | ovr_q | ferr_q | perr_q;

    logic unused_apb_bits;
`ifdef APB_UART_RX_PARITY_EN
    assign unused_apb_bits = ^{paddr_i[31:ADDR_LSB_W], paddr_i[ADDR_LSB_W-3:0],
                               pwdata_i[31:5], pwdata_i[1:0]};
`else
    assign unused_apb_bits = ^{paddr_i[31:ADDR_LSB_W], paddr_i[ADDR_LSB_W-3:0],
                               pwdata_i[31:4], pwdata_i[1:0]};
`endif

endmodule

// File: doc/apb_uart_rx.md
Name: apb_uart_rx

Overview:
- UART receive stage with an APB slave readback port; the receive-side counterpart of the APB-fed UART transmit path.
- Deserialises 8N1 frames from the serial line (8E1 with parity) and buffers bytes in an internal FIFO.
- Returns bytes and status on prdata toward the AHB-to-APB bridge, supplying the bridge's prdata_i input.

Parameters:
- CLKS_PER_BIT, 434, pclk cycles per UART bit (50 MHz / 115200); legal range >= 4.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64.
- ADDR_LSB_W, 4, low paddr bits decoded for register select.

Ports:
- pclk  in  1  single clock; all logic on rising edge.
- preset  in  1  synchronous reset, active-high.
- uart_rx_i  in  1  asynchronous serial input; idle high.
- psel_i  in  1  APB slave select for this block.
- penable_i  in  1  APB access phase.
- pwrite_i  in  1  APB write when 1, read when 0.
- paddr_i  in  32  APB address; only bits [3:2] decoded.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data; combinational from register state.
- rx_irq_o  out  1  high while FIFO is not empty or any sticky error flag is set.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - FSM to IDLE; FIFO emptied; all sticky flags cleared.
  - Synchroniser flops set to 1; rx_irq_o=0.
  - prdata_o=0 while psel_i=0.
- Synchroniser: 2-flop on uart_rx_i; FSM uses only the second stage (rx_s); 2-cycle input latency.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: on a falling edge of rx_s (previous 1, current 0), clear baud counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles (integer divide), sample rx_s.
    - 0: go to DATA with bit index 0.
    - 1: glitch; return to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7, go to PARITY if the macro is defined, otherwise STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: push the byte, then IDLE.
    - 0: set FERR sticky, discard the byte, then IDLE. IDLE then waits for rx_s=1 before arming a new edge detect, so a break does not retrigger.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0; sampling occurs on the wrap.
- FIFO:
  - Width 8; pointers log2(FIFO_DEPTH)+1 bits with wrap bit.
  - empty = pointers equal; full = indices equal with wrap bits differing.
- Push while full and no pop in the same cycle: byte dropped, OVR sticky set, FIFO unchanged.
- Push and pop in the same cycle:
  - Both take effect; count unchanged.
  - When full, the pop frees the slot and the push is accepted (no OVR).
  - When empty, the push is accepted and the pop is ignored (count becomes 1).
- APB: zero wait states, no pready. An access completes when psel_i & penable_i.
- Register map (by paddr_i[3:2]):
  - 0 RXDATA (RO): prdata_o = {24'b0, FIFO head}, or 0 when empty. A completed read pops one entry when non-empty; a read when empty changes nothing.
  - 1 STATUS (R/W1C): bit0 EMPTY, bit1 FULL, bit2 OVR, bit3 FERR, bit4 PERR, bits[31:5]=0. A completed write clears each sticky bit where pwdata_i is 1. EMPTY and FULL are read-only.
  - 2 LEVEL (RO): prdata_o = FIFO occupancy, zero-extended.
  - 3: reads 0; writes ignored.
- Read-modify conflict: if a sticky flag sets in the same cycle as a W1C clear of that flag, the set wins.
- Writes to RO registers are ignored.
- Reset mid-frame: the partial byte is discarded; the FSM restarts at IDLE and the next falling edge after rx_s returns high begins a new frame.

Optional Feature:
- Macro: APB_UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; one bit sampled after CLKS_PER_BIT cycles.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0; on mismatch set PERR sticky.
  - The byte is still pushed if the stop bit is valid.
- Undefined:
  - No PARITY state; frame is 10 bits.
  - STATUS bit4 reads 0 and is not writable.

Test Plan:
- CLKS_PER_BIT=16: reset, then drive frame 0xA5 on uart_rx_i -> LEVEL reads 1, STATUS=0x0; RXDATA read returns 0x000000A5; STATUS then reads 0x1.
- 0.25-bit low glitch (4 cycles) on an idle line -> no push, LEVEL stays 0, no flags.
- Send 9 bytes 0x00..0x08 with FIFO_DEPTH=8 and no reads -> STATUS=0x6 (FULL, OVR); 8 RXDATA reads return 0x00..0x07. Write STATUS 0x4 -> OVR cleared, reads 0x1.
- Frame 0x3C with stop bit held 0 -> FERR set, LEVEL 0, rx_irq_o=1; after the line returns high, frame 0x11 is received correctly.
- FIFO full, last stop-bit sample coincides with a completed RXDATA read -> LEVEL stays 8, no OVR, oldest byte returned.
- With APB_UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> byte pushed, PERR set; with parity bit 1 -> pushed, no PERR. Assert preset mid-DATA -> LEVEL 0, STATUS 0x1.
